// File: rtl/serial_word_tx_ctrl_if.sv
// serial_word_tx_ctrl_if: word-in / bit-out handshake bundle for serial_word_tx_ctrl
// Ports (slave = controller side):
//   in_data, in_len, in_valid / in_ready : parallel word handshake
//   s_data, s_valid / s_ready            : serial bit handshake
//   abort                                : synchronous cancel of the word in flight
//   busy, done, bit_cnt                  : status
interface serial_word_tx_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
);
   logic [WIDTH-1:0] in_data;
   logic [CNT_W-1:0] in_len;
   logic             in_valid;
   logic             in_ready;
   logic             s_data;
   logic             s_valid;
   logic             s_ready;
   logic             abort;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] bit_cnt;
   modport master (
      output in_data, in_len, in_valid, s_ready, abort,
      input  in_ready, s_data, s_valid, busy, done, bit_cnt
   );
   modport slave (
      input  in_data, in_len, in_valid, s_ready, abort,
      output in_ready, s_data, s_valid, busy, done, bit_cnt
   );
endinterface

// File: rtl/serial_word_tx_ctrl.sv
// serial_word_tx_ctrl: loads parallel words and shifts them out MSB-first over a valid/ready bit stream
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_word_tx_ctrl_if.slave (word input, serial output, abort, status)
module serial_word_tx_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                        clk,
   input  logic                        rst_n,
   serial_word_tx_ctrl_if.slave        bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] w;
   logic [CNT_W-1:0] len_r;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] len_eff;
   // A zero or oversized length means "send the whole word".
   assign len_eff = (bus.in_len == '0 || bus.in_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.in_len;
   assign bus.in_ready = (state == IDLE);
   assign bus.s_valid  = (state == SHIFT);
   assign bus.s_data   = w[WIDTH-1];
   assign bus.busy     = (state != IDLE);
   assign bus.done     = (state == DONE);
   assign bus.bit_cnt  = cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         w     <= '0;
         len_r <= '0;
         cnt   <= '0;
      end else if (bus.abort) begin
         state <= IDLE;
         w     <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               w     <= bus.in_data;
               len_r <= len_eff;
               cnt   <= '0;
               state <= SHIFT;
            end
            SHIFT: if (bus.s_ready) begin
               w   <= {w[WIDTH-2:0], 1'b0};
               cnt <= cnt + 1'b1;
               if (cnt == len_r - 1'b1) state <= DONE;
            end
            DONE: begin
               // cnt keeps the final count so status can still be read after the word
               w     <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_word_tx_ctrl.sv
// tb_serial_word_tx_ctrl: directed plus randomized checks of serial_word_tx_ctrl against a bit-queue reference model
module tb_serial_word_tx_ctrl;
   localparam int WIDTH = 32;
   localparam int CNT_W = 6;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   serial_word_tx_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus();
   serial_word_tx_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int checks = 0;
   int failures = 0;
   // reference model: bits still to send, the loaded word, bits sent so far, done pulse pending
   bit               q[$];
   logic [WIDTH-1:0] m_word;
   int               m_sent;
   bit               m_done;
   task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic model_reset();
      q.delete();
      m_word = '0;
      m_sent = 0;
      m_done = 1'b0;
   endtask
   task automatic check_outputs(string tag);
      logic [WIDTH-1:0] sh;
      bit idle;
      sh = m_word << m_sent;
      idle = (q.size() == 0) && !m_done;
      check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(idle));
      check({tag, ".s_valid"}, 64'(bus.s_valid), 64'(q.size() != 0));
      check({tag, ".s_data"}, 64'(bus.s_data), 64'(sh[WIDTH-1]));
      check({tag, ".busy"}, 64'(bus.busy), 64'(!idle));
      check({tag, ".done"}, 64'(bus.done), 64'(m_done));
      check({tag, ".bit_cnt"}, 64'(bus.bit_cnt), 64'(m_sent));
   endtask
   task automatic drive(logic [WIDTH-1:0] d, logic [CNT_W-1:0] l, logic v, logic r, logic a);
      bus.in_data  = d;
      bus.in_len   = l;
      bus.in_valid = v;
      bus.s_ready  = r;
      bus.abort    = a;
   endtask
   // advance one clock: model follows the rules from the currently driven inputs, then outputs are compared
   task automatic tick(string tag);
      int len;
      if (bus.abort) model_reset();
      else if (m_done) begin
         m_done = 1'b0;
         m_word = '0;
      end else if (q.size() != 0) begin
         if (bus.s_ready) begin
            void'(q.pop_front());
            m_sent++;
            if (q.size() == 0) m_done = 1'b1;
         end
      end else if (bus.in_valid) begin
         len = (bus.in_len == 0 || int'(bus.in_len) > WIDTH) ? WIDTH : int'(bus.in_len);
         m_word = bus.in_data;
         m_sent = 0;
         for (int i = 0; i < len; i++) q.push_back(bus.in_data[WIDTH-1-i]);
      end
      @(posedge clk);
      @(negedge clk);
      check_outputs(tag);
   endtask
   // accept a word with s_ready high, drain it, return the serial bits observed and cycles to done
   task automatic send_word(string tag, logic [WIDTH-1:0] d, logic [CNT_W-1:0] l,
                            output logic [WIDTH-1:0] bits, output int nbits);
      int guard;
      bits = '0;
      nbits = 0;
      guard = 0;
      drive(d, l, 1'b1, 1'b1, 1'b0);
      tick({tag, ".acc"});
      bus.in_valid = 1'b0;
      while (bus.s_valid === 1'b1 && guard < 100) begin
         bits = {bits[WIDTH-2:0], bus.s_data};
         nbits++;
         guard++;
         tick(tag);
      end
      check({tag, ".timeout"}, 64'(guard < 100), 64'(1));
      check({tag, ".done_after"}, 64'(bus.done), 64'(1));
      tick({tag, ".post"});
      check({tag, ".ready_again"}, 64'(bus.in_ready), 64'(1));
   endtask
   initial begin
      logic [WIDTH-1:0] bits;
      int nbits;
      logic [6:0] pat;
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      model_reset();
      @(negedge clk);
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      tick("idle");
      // 1: 8 bits of 0xA5
      send_word("t1", 32'hA500_0000, 6'd8, bits, nbits);
      check("t1.nbits", 64'(nbits), 64'(8));
      check("t1.bits", 64'(bits[7:0]), 64'(8'hA5));
      // 2: full-word length via 0 and via oversize
      send_word("t2a", 32'h8000_0001, 6'd0, bits, nbits);
      check("t2a.nbits", 64'(nbits), 64'(32));
      check("t2a.bits", 64'(bits), 64'(32'h8000_0001));
      send_word("t2b", 32'h8000_0001, 6'd40, bits, nbits);
      check("t2b.nbits", 64'(nbits), 64'(32));
      check("t2b.bits", 64'(bits), 64'(32'h8000_0001));
      // 3: back-pressure pattern 1,0,0,1,0,1,1
      drive(32'hF000_0000, 6'd4, 1'b1, 1'b1, 1'b0);
      tick("t3.acc");
      bus.in_valid = 1'b0;
      pat = 7'b1001011;
      for (int i = 6; i >= 0; i--) begin
         bus.s_ready = pat[i];
         tick("t3");
      end
      check("t3.done", 64'(bus.done), 64'(1));
      check("t3.cnt", 64'(bus.bit_cnt), 64'(4));
      bus.s_ready = 1'b1;
      tick("t3.post");
      // 4: abort after 3 transfers
      drive(32'hFF00_0000, 6'd8, 1'b1, 1'b1, 1'b0);
      tick("t4.acc");
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick("t4");
      bus.abort = 1'b1;
      tick("t4.abort");
      check("t4.s_valid", 64'(bus.s_valid), 64'(0));
      check("t4.cnt", 64'(bus.bit_cnt), 64'(0));
      bus.abort = 1'b0;
      for (int i = 0; i < 4; i++) tick("t4.quiet");
      send_word("t4n", 32'h5000_0000, 6'd4, bits, nbits);
      check("t4n.bits", 64'(bits[3:0]), 64'(4'h5));
      // 5: asynchronous reset mid-shift
      drive(32'hFFFF_0000, 6'd16, 1'b1, 1'b1, 1'b0);
      tick("t5.acc");
      bus.in_valid = 1'b0;
      tick("t5");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("t5.rst_s_valid", 64'(bus.s_valid), 64'(0));
      check("t5.rst_busy", 64'(bus.busy), 64'(0));
      check("t5.rst_cnt", 64'(bus.bit_cnt), 64'(0));
      @(negedge clk);
      check_outputs("t5.rst");
      rst_n = 1'b1;
      send_word("t5n", 32'hC000_0000, 6'd2, bits, nbits);
      check("t5n.bits", 64'(bits[1:0]), 64'(2'b11));
      check("t5n.nbits", 64'(nbits), 64'(2));
      // 6: two back-to-back words with in_valid held
      drive(32'hE000_0000, 6'd3, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i <= 9; i++) begin
         tick("t6");
         if (i == 6) bus.in_valid = 1'b0;
         if (i == 4) check("t6.first_done", 64'(bus.done), 64'(1));
      end
      check("t6.second_done", 64'(bus.done), 64'(1));
      tick("t6.post");
      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         drive($urandom, CNT_W'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 99) < 3));
         tick("rnd");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
